// File: rtl/instruction_fetch_if.sv
// Program-memory read bus plus the decoder-side instruction handshake
// for the Jimmy instruction fetch unit.
//   master : fetch unit
//            drives address_bus, instr_opcode, instr_operand, instr_two_byte,
//            instr_pc and instr_valid;
//            reads data_bus, instr_ready, branch_taken and branch_target.
//   slave  : memory/decoder side (the opposite directions).
interface instruction_fetch_if;
  logic [7:0] address_bus;
  logic [7:0] data_bus;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic       instr_two_byte;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       branch_taken;
  logic [7:0] branch_target;

  modport master (
    output address_bus, instr_opcode, instr_operand, instr_two_byte,
           instr_pc, instr_valid,
    input  data_bus, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  address_bus, instr_opcode, instr_operand, instr_two_byte,
           instr_pc, instr_valid,
    output data_bus, instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads one- or two-byte instructions from a
// combinational program memory, holds each one for the decoder until it
// is accepted through a valid/ready handshake, and applies branch
// redirects that arrive together with that handshake.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : instruction_fetch_if.master (memory address/data, instruction
//           outputs, instr_ready, branch_taken, branch_target)
module instruction_fetch #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter logic [7:0] NOP_OPCODE   = 8'h70
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t     state_reg;
  logic [7:0] pc_reg;
  logic [7:0] opcode_reg;
  logic [7:0] operand_reg;
  logic       two_byte_reg;
  logic [7:0] instr_pc_reg;
  logic       valid_reg;
  logic       op_is_two_byte;

  // Opcode classes that carry an immediate/target byte:
  // LD_IMM, CMP_IMM, BRA, BHI, BEQ.
  always_comb begin
    op_is_two_byte = 1'b0;
    case (bus.data_bus[7:2])
      6'b100000, 6'b100011, 6'b101010,
      6'b101100, 6'b101101: op_is_two_byte = 1'b1;
      default:              op_is_two_byte = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= FETCH_OP;
      pc_reg       <= RESET_VECTOR;
      opcode_reg   <= NOP_OPCODE;
      operand_reg  <= 8'h00;
      two_byte_reg <= 1'b0;
      instr_pc_reg <= RESET_VECTOR;
      valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        FETCH_OP: begin
          opcode_reg   <= bus.data_bus;
          instr_pc_reg <= pc_reg;
          pc_reg       <= pc_reg + 8'd1;
          two_byte_reg <= op_is_two_byte;
          if (op_is_two_byte) begin
            // valid stays low until the operand byte is in
            state_reg <= FETCH_IMM;
          end else begin
            operand_reg <= 8'h00;
            valid_reg   <= 1'b1;
            state_reg   <= HOLD;
          end
        end
        FETCH_IMM: begin
          // pc wraps modulo 256, so an opcode at FF reads its operand from 00
          operand_reg <= bus.data_bus;
          pc_reg      <= pc_reg + 8'd1;
          valid_reg   <= 1'b1;
          state_reg   <= HOLD;
        end
        HOLD: begin
          // Outputs frozen until accepted; pc already points past the
          // instruction, so only a taken branch changes it here.
          if (bus.instr_ready) begin
            valid_reg <= 1'b0;
            state_reg <= FETCH_OP;
            if (bus.branch_taken) begin
              pc_reg <= bus.branch_target;
            end
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= FETCH_OP;
        end
      endcase
    end
  end

  assign bus.address_bus    = pc_reg;
  assign bus.instr_opcode   = opcode_reg;
  assign bus.instr_operand  = operand_reg;
  assign bus.instr_two_byte = two_byte_reg;
  assign bus.instr_pc       = instr_pc_reg;
  assign bus.instr_valid    = valid_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic clk;
  logic reset_a;
  logic reset_b;
  logic use_rand;
  logic [7:0] rand_byte;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  int n_cmp;
  int n_err;

  instruction_fetch_if if_a ();
  instruction_fetch_if if_b ();

  instruction_fetch #(.RESET_VECTOR(8'h00), .NOP_OPCODE(8'h70)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (if_a)
  );

  instruction_fetch #(.RESET_VECTOR(8'hFE), .NOP_OPCODE(8'h70)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (if_b)
  );

  // Combinational program memories
  assign if_a.data_bus = use_rand ? rand_byte : mem_a[if_a.address_bus];
  assign if_b.data_bus = mem_b[if_b.address_bus];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic vld, input logic [7:0] opc,
                       input logic [7:0] opd, input logic two, input logic [7:0] ipc,
                       input logic [7:0] addr);
    chk({tag, ".valid"},    {7'b0, if_a.instr_valid},    {7'b0, vld});
    chk({tag, ".opcode"},   if_a.instr_opcode,           opc);
    chk({tag, ".operand"},  if_a.instr_operand,          opd);
    chk({tag, ".two_byte"}, {7'b0, if_a.instr_two_byte}, {7'b0, two});
    chk({tag, ".pc"},       if_a.instr_pc,               ipc);
    chk({tag, ".addr"},     if_a.address_bus,            addr);
    $display("step %s: valid=%0b op=%h opd=%h two=%0b ipc=%h addr=%h", tag,
             if_a.instr_valid, if_a.instr_opcode, if_a.instr_operand,
             if_a.instr_two_byte, if_a.instr_pc, if_a.address_bus);
  endtask

  task automatic chk_b(input string tag, input logic vld, input logic [7:0] opc,
                       input logic [7:0] opd, input logic two, input logic [7:0] ipc,
                       input logic [7:0] addr);
    chk({tag, ".valid"},    {7'b0, if_b.instr_valid},    {7'b0, vld});
    chk({tag, ".opcode"},   if_b.instr_opcode,           opc);
    chk({tag, ".operand"},  if_b.instr_operand,          opd);
    chk({tag, ".two_byte"}, {7'b0, if_b.instr_two_byte}, {7'b0, two});
    chk({tag, ".pc"},       if_b.instr_pc,               ipc);
    chk({tag, ".addr"},     if_b.address_bus,            addr);
    $display("step %s: valid=%0b op=%h opd=%h two=%0b ipc=%h addr=%h", tag,
             if_b.instr_valid, if_b.instr_opcode, if_b.instr_operand,
             if_b.instr_two_byte, if_b.instr_pc, if_b.address_bus);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h48;
      mem_b[i] = 8'h48;
    end
    // Factorial program fragment
    mem_a[8'h00] = 8'h98; mem_a[8'h01] = 8'h81; mem_a[8'h02] = 8'h01;
    mem_a[8'h03] = 8'h8C; mem_a[8'h04] = 8'h00; mem_a[8'h05] = 8'hB4;
    mem_a[8'h06] = 8'h0C; mem_a[8'h07] = 8'h48; mem_a[8'h0C] = 8'h9D;
    mem_a[8'h0D] = 8'h81; mem_a[8'h0E] = 8'h22;
    // Wrap-around program
    mem_b[8'hFE] = 8'h48; mem_b[8'hFF] = 8'hA8; mem_b[8'h00] = 8'h05;

    reset_a = 1'b0;
    reset_b = 1'b0;
    use_rand = 1'b1;
    rand_byte = 8'h00;
    if_a.instr_ready   = 1'b1;
    if_a.branch_taken  = 1'b0;
    if_a.branch_target = 8'h00;
    if_b.instr_ready   = 1'b1;
    if_b.branch_taken  = 1'b0;
    if_b.branch_target = 8'h00;

    // T1: reset held with random data on the bus
    for (int i = 0; i < 3; i++) begin
      rand_byte = 8'($urandom_range(0, 255));
      tick();
      chk_a("t1_reset", 1'b0, 8'h70, 8'h00, 1'b0, 8'h00, 8'h00);
    end
    reset_a = 1'b1;
    use_rand = 1'b0;

    // T2: sequential fetch with ready high
    tick(); chk_a("t2_98",      1'b1, 8'h98, 8'h00, 1'b0, 8'h00, 8'h01);
    tick(); chk_a("t2_hs98",    1'b0, 8'h98, 8'h00, 1'b0, 8'h00, 8'h01);
    tick(); chk_a("t2_81op",    1'b0, 8'h81, 8'h00, 1'b1, 8'h01, 8'h02);
    tick(); chk_a("t2_81imm",   1'b1, 8'h81, 8'h01, 1'b1, 8'h01, 8'h03);

    // T4: stall on 81/01; a branch request while not handshaking is ignored
    if_a.instr_ready   = 1'b0;
    if_a.branch_taken  = 1'b1;
    if_a.branch_target = 8'h40;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_a("t4_stall", 1'b1, 8'h81, 8'h01, 1'b1, 8'h01, 8'h03);
    end
    if_a.instr_ready  = 1'b1;
    if_a.branch_taken = 1'b0;
    tick(); chk_a("t4_release", 1'b0, 8'h81, 8'h01, 1'b1, 8'h01, 8'h03);
    tick(); chk_a("t2_8Cop",    1'b0, 8'h8C, 8'h01, 1'b1, 8'h03, 8'h04);
    // branch request during FETCH_IMM must be ignored
    if_a.branch_taken  = 1'b1;
    if_a.branch_target = 8'h40;
    tick(); chk_a("t2_8Cimm",   1'b1, 8'h8C, 8'h00, 1'b1, 8'h03, 8'h05);
    if_a.branch_taken = 1'b0;
    tick(); chk_a("t2_hs8C",    1'b0, 8'h8C, 8'h00, 1'b1, 8'h03, 8'h05);
    tick(); chk_a("t2_B4op",    1'b0, 8'hB4, 8'h00, 1'b1, 8'h05, 8'h06);
    tick(); chk_a("t2_B4imm",   1'b1, 8'hB4, 8'h0C, 1'b1, 8'h05, 8'h07);

    // T3: taken branch with the handshake
    if_a.branch_taken  = 1'b1;
    if_a.branch_target = 8'h0C;
    tick(); chk_a("t3_branch",  1'b0, 8'hB4, 8'h0C, 1'b1, 8'h05, 8'h0C);
    if_a.branch_taken = 1'b0;
    tick(); chk_a("t3_9D",      1'b1, 8'h9D, 8'h00, 1'b0, 8'h0C, 8'h0D);
    tick(); chk_a("t3_hs9D",    1'b0, 8'h9D, 8'h00, 1'b0, 8'h0C, 8'h0D);
    tick(); chk_a("t6_81op",    1'b0, 8'h81, 8'h00, 1'b1, 8'h0D, 8'h0E);

    // T6: asynchronous reset in FETCH_IMM, observed before the next edge
    #2 reset_a = 1'b0;
    #1 chk_a("t6_async",        1'b0, 8'h70, 8'h00, 1'b0, 8'h00, 8'h00);
    tick(); chk_a("t6_held",    1'b0, 8'h70, 8'h00, 1'b0, 8'h00, 8'h00);
    reset_a = 1'b1;
    tick(); chk_a("t6_refetch", 1'b1, 8'h98, 8'h00, 1'b0, 8'h00, 8'h01);

    // Tight loop: branch to the instruction's own address
    if_a.branch_taken  = 1'b1;
    if_a.branch_target = 8'h00;
    tick(); chk_a("loop_hs",    1'b0, 8'h98, 8'h00, 1'b0, 8'h00, 8'h00);
    if_a.branch_taken = 1'b0;
    tick(); chk_a("loop_98",    1'b1, 8'h98, 8'h00, 1'b0, 8'h00, 8'h01);

    // T5: PC wrap with RESET_VECTOR=FE
    chk_b("t5_reset",           1'b0, 8'h70, 8'h00, 1'b0, 8'hFE, 8'hFE);
    reset_b = 1'b1;
    tick(); chk_b("t5_48",      1'b1, 8'h48, 8'h00, 1'b0, 8'hFE, 8'hFF);
    tick(); chk_b("t5_hs48",    1'b0, 8'h48, 8'h00, 1'b0, 8'hFE, 8'hFF);
    tick(); chk_b("t5_A8op",    1'b0, 8'hA8, 8'h00, 1'b1, 8'hFF, 8'h00);
    tick(); chk_b("t5_A8imm",   1'b1, 8'hA8, 8'h05, 1'b1, 8'hFF, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
